clk_div_ctrl: RTL and testbench

Run-time controller for the pixel/system clock-enable divider. It is fed by the fast `clk`, e.g. 252 MHz. It produces a divided square wave and a one-cycle clock-enable strobe at `clk`/N. The divisor N is reprogrammed through a req/ack handshake and is applied only at a period boundary, so downstream video/CPU logic never sees a runt period. Sits beside the clock divider at the top level and is driven by the mode/config register logic.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ctrl.sv | 115 +++++++++++
 tb/tb_clk_div_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the run-time clock-enable divider controller.
package clk_div_pkg;

  // Default counter/divisor width and the divisor loaded at reset.
  localparam int DIV_CNT_W   = 4;
  localparam int DIV_DEFAULT = 10;

  // Smallest divisor that still yields a real period (one high, one low).
  localparam int MIN_DIV     = 2;

  // clk_out is high while count < divisor >> HALF_SHIFT.
  localparam int HALF_SHIFT  = 1;

endpackage

// File: rtl/clk_div_ctrl.sv
// Clock-enable divider with a glitch-free divisor change handshake.
// A new divisor is only applied on a period boundary (or at once while
// parked), so downstream logic never sees a runt period.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DIV_CNT_W,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_en,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);

  logic [CNT_W-1:0] count_reg,    count_next;
  logic [CNT_W-1:0] cur_div_reg,  cur_div_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             busy_reg,     busy_next;
  logic             ack_reg,      ack_next;
  logic             err_reg,      err_next;
  logic             clk_en_reg,   clk_en_next;
  logic             clk_out_reg,  clk_out_next;

  // Shared decision terms: wrap drives the counter, the outputs and the
  // moment a pending divisor may take effect.
  logic             wrap;
  logic             capture;
  logic             reject;
  logic             apply;
  logic [CNT_W-1:0] div_eff;

  // Next-state logic for counter, request capture/apply and output strobes.
  always_comb begin
    count_next    = count_reg;
    cur_div_next  = cur_div_reg;
    pend_div_next = pend_div_reg;
    busy_next     = busy_reg;
    ack_next      = 1'b0;
    err_next      = 1'b0;
    clk_en_next   = 1'b0;
    clk_out_next  = 1'b0;

    wrap    = (count_reg == (cur_div_reg - ONE));
    // A request is ignored while one is pending and in the ack cycle.
    capture = div_req && !busy_reg && !ack_reg;
    reject  = capture && (div_val < DIV_MIN);
    // Apply only needs busy_reg, so it can never coincide with a capture.
    apply   = busy_reg && (!run || wrap);
    div_eff = apply ? pend_div_reg : cur_div_reg;

    if (apply) begin
      cur_div_next = pend_div_reg;
      busy_next    = 1'b0;
      ack_next     = 1'b1;
    end else if (reject) begin
      ack_next = 1'b1;
      err_next = 1'b1;
    end else if (capture) begin
      pend_div_next = div_val;
      busy_next     = 1'b1;
    end

    if (run) begin
      count_next   = wrap ? '0 : (count_reg + ONE);
      clk_en_next  = wrap;
      clk_out_next = (count_next < (div_eff >> HALF_SHIFT));
    end else begin
      // Park just before the wrap so a restart begins a full period.
      count_next = div_eff - ONE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= DIV_RST - ONE;
      cur_div_reg  <= DIV_RST;
      pend_div_reg <= DIV_RST;
      busy_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      clk_en_reg   <= 1'b0;
      clk_out_reg  <= 1'b0;
    end else begin
      count_reg    <= count_next;
      cur_div_reg  <= cur_div_next;
      pend_div_reg <= pend_div_next;
      busy_reg     <= busy_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      clk_en_reg   <= clk_en_next;
      clk_out_reg  <= clk_out_next;
    end
  end

  assign div_ack = ack_reg;
  assign div_err = err_reg;
  assign busy    = busy_reg;
  assign cur_div = cur_div_reg;
  assign clk_en  = clk_en_reg;
  assign clk_out = clk_out_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised scoreboard bench for clk_div_ctrl against a period-level model.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       div_req;
  logic [3:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic       busy;
  logic [3:0] cur_div;
  logic       clk_en;
  logic       clk_out;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  typedef struct packed {
    logic       err;
    logic [3:0] div;
  } exp_t;

  exp_t sb[$];

  clk_div_ctrl #(.CNT_W(4), .DEFAULT_DIV(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .cur_div (cur_div),
    .clk_en  (clk_en),
    .clk_out (clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the position inside the current period and the
  // divisor in force; a period ends after m_div cycles, a pending divisor
  // takes over only when a period ends or while stopped.
  int m_div, m_pos, m_pend;
  bit m_active, m_busy, m_ack;

  always @(posedge clk) begin
    bit period_end, do_apply, do_take;
    if (!rst_n) begin
      m_div = 10; m_pos = 9; m_pend = 0;
      m_active = 0; m_busy = 0; m_ack = 0;
      sb.delete();
    end else begin
      period_end = (m_pos == m_div - 1);
      do_apply   = m_busy && (!run || period_end);
      do_take    = div_req && !m_busy && !m_ack;
      m_ack = 0;
      if (do_apply) begin
        m_div  = m_pend;
        m_busy = 0;
        m_ack  = 1;
        sb.push_back('{1'b0, 4'(m_pend)});
      end else if (do_take) begin
        if (int'(div_val) < 2) begin
          m_ack = 1;
          sb.push_back('{1'b1, 4'(m_div)});
        end else begin
          m_busy = 1;
          m_pend = int'(div_val);
        end
      end
      if (run) begin
        m_pos    = period_end ? 0 : m_pos + 1;
        m_active = 1;
      end else begin
        m_pos    = m_div - 1;
        m_active = 0;
      end
    end
    #1;
    chk("clk_en",  int'(clk_en),  int'(m_active && m_pos == 0));
    chk("clk_out", int'(clk_out), int'(m_active && (m_pos < m_div / 2)));
    chk("busy",    int'(busy),    int'(m_busy));
    chk("cur_div", int'(cur_div), m_div);
  end

  // Monitor: every ack the DUT presents must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && div_ack) begin
      if (sb.size() == 0) begin
        chk("ack_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("div_err", int'(div_err), int'(e.err));
        chk("ack_div", int'(cur_div), int'(e.div));
        $display("ack: err=%0d cur_div=%0d (exp err=%0d div=%0d) t=%0t",
                 div_err, cur_div, e.err, e.div, $time);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the request until ack; optionally change div_val while busy.
  task automatic do_req(input logic [3:0] v, input logic [3:0] v2, input bit swap);
    int n;
    n = 0;
    @(negedge clk);
    div_req = 1'b1;
    div_val = v;
    do begin
      @(negedge clk);
      n++;
      if (swap && busy) div_val = v2;
    end while (!div_ack && n < 100);
    if (!div_ack) chk("req_timeout", 0, 1);
    div_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; div_req = 1'b0; div_val = '0;
    cycles(3);
    rst_n = 1'b1;
    // Normal run at the reset divisor.
    run = 1'b1;
    cycles(35);
    // Legal change, then rejected divisors.
    do_req(4'd4, 4'd4, 1'b0);
    cycles(12);
    do_req(4'd1, 4'd1, 1'b0);
    do_req(4'd0, 4'd0, 1'b0);
    cycles(9);
    // Mid-period stop and restart.
    run = 1'b0;
    cycles(4);
    run = 1'b1;
    cycles(15);
    // Change to 5 with div_val wiggled to 7 while busy.
    do_req(4'd5, 4'd7, 1'b1);
    cycles(17);
    // Async reset while a request is pending.
    @(negedge clk);
    div_req = 1'b1;
    div_val = 4'd3;
    @(negedge clk);
    chk("busy_before_rst", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clk_en",  int'(clk_en),  0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_ack",     int'(div_ack), 0);
    chk("rst_cur_div", int'(cur_div), 10);
    div_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(12);
    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (div_req && div_ack) begin
        div_req = 1'b0;
      end else if (!div_req && $urandom_range(0, 9) == 0) begin
        div_req = 1'b1;
        div_val = 4'($urandom_range(0, 15));
      end else if (div_req && busy && $urandom_range(0, 3) == 0) begin
        div_val = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) run = ~run;
    end
    // Let any outstanding request finish.
    if (div_req) begin
      for (int i = 0; i < 40 && !div_ack; i++) @(negedge clk);
      div_req = 1'b0;
    end
    run = 1'b1;
    cycles(40);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
